// File: rtl/scmp_bus_responder.sv
module scmp_bus_responder #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] addr,
  input  logic        ADS_n,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic [7:0]  D_i,
  output logic [7:0]  D_o,
  output logic        D_oe,
  output logic        hold_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [3:0]  cyc_flags,
  output logic        halt_o,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD_WAIT,
    S_RD_DRIVE,
    S_WR_WAIT,
    S_WR_END
  } state_e;

  state_e      state_q;
  logic [7:0]  d_o_q;
  logic        d_oe_q;
  logic        hold_n_q;
  logic [15:0] mem_addr_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [7:0]  mem_wdata_q;
  logic [3:0]  cyc_flags_q;
  logic        halt_q;
  logic        err_q;

  logic        ads_take;
  logic        ads_stray;

`ifdef SCMP_RESP_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] tmo_q;
`endif

  always_comb begin
    ads_take  = 1'b0;
    ads_stray = 1'b0;
    if (!ADS_n) begin
      if (state_q == S_IDLE || state_q == S_ADDR) begin
        ads_take = 1'b1;
      end else begin
        ads_stray = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      cyc_flags_q <= '0;
      halt_q      <= 1'b0;
    end else begin
      halt_q <= ads_take & D_i[7] & D_i[5];
      if (ads_take) begin
        mem_addr_q  <= {D_i[3:0], addr};
        cyc_flags_q <= D_i[7:4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      d_o_q       <= '0;
      d_oe_q      <= 1'b0;
      hold_n_q    <= 1'b1;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
`ifdef SCMP_RESP_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      err_q <= ads_stray;
      case (state_q)
        S_IDLE: begin
          if (!ADS_n) begin
            state_q <= S_ADDR;
`ifdef SCMP_RESP_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        S_ADDR: begin
          if (!ADS_n) begin
            state_q <= S_ADDR;
`ifdef SCMP_RESP_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end else if (!RD_n && !WR_n) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (!RD_n) begin
            mem_rd_q <= 1'b1;
            hold_n_q <= 1'b0;
            state_q  <= S_RD_WAIT;
          end else if (!WR_n) begin
            mem_wdata_q <= D_i;
            mem_wr_q    <= 1'b1;
            hold_n_q    <= 1'b0;
            state_q     <= S_WR_WAIT;
          end
`ifdef SCMP_RESP_TIMEOUT_EN
          else if (tmo_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        S_RD_WAIT: begin
          if (mem_ack) begin
            d_o_q    <= mem_rdata;
            d_oe_q   <= 1'b1;
            mem_rd_q <= 1'b0;
            hold_n_q <= 1'b1;
            state_q  <= S_RD_DRIVE;
          end
        end
        S_RD_DRIVE: begin
          if (RD_n) begin
            d_oe_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_WR_WAIT: begin
          if (mem_ack) begin
            mem_wr_q <= 1'b0;
            hold_n_q <= 1'b1;
            state_q  <= S_WR_END;
          end
        end
        S_WR_END: begin
          if (WR_n) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign D_o       = d_o_q;
  assign D_oe      = d_oe_q;
  assign hold_n    = hold_n_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign cyc_flags = cyc_flags_q;
  assign halt_o    = halt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_scmp_bus_responder.sv
module tb_scmp_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] addr;
  logic        ADS_n, RD_n, WR_n;
  logic [7:0]  D_i;
  logic [7:0]  D_o;
  logic        D_oe, hold_n;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [3:0]  cyc_flags;
  logic        halt_o, err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  scmp_bus_responder #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .ADS_n(ADS_n), .RD_n(RD_n), .WR_n(WR_n),
    .D_i(D_i), .D_o(D_o), .D_oe(D_oe), .hold_n(hold_n), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .cyc_flags(cyc_flags), .halt_o(halt_o), .err(err)
  );

  typedef struct packed {
    logic        ads_n, rd_n, wr_n;
    logic [11:0] a;
    logic [7:0]  d;
    logic        ack;
    logic [7:0]  rdata;
    logic [5:0]  ctl;
    logic [7:0]  dout;
    logic [15:0] maddr;
    logic [3:0]  cyc;
    logic [7:0]  wd;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic ads_n, logic rd_n, logic wr_n, logic [11:0] a, logic [7:0] d,
                              logic ack, logic [7:0] rdata, logic [5:0] ctl, logic [7:0] dout,
                              logic [15:0] maddr, logic [3:0] cyc, logic [7:0] wd);
    vec_t v;
    v.ads_n = ads_n; v.rd_n = rd_n; v.wr_n = wr_n; v.a = a; v.d = d;
    v.ack = ack; v.rdata = rdata; v.ctl = ctl; v.dout = dout;
    v.maddr = maddr; v.cyc = cyc; v.wd = wd;
    return v;
  endfunction

  function automatic logic [41:0] outs();
    return {hold_n, mem_rd, mem_wr, D_oe, err, halt_o, D_o, mem_addr, cyc_flags, mem_wdata};
  endfunction

  task automatic chk(input string name, input logic [41:0] got, input logic [41:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic ads_n, input logic rd_n, input logic wr_n, input logic [11:0] a,
                       input logic [7:0] d, input logic ack, input logic [7:0] rdata);
    ADS_n = ads_n; RD_n = rd_n; WR_n = wr_n; addr = a; D_i = d;
    mem_ack = ack; mem_rdata = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1, 1, 1, 12'h000, 8'h00, 0, 8'h00);

    vecs[0]  = mk(1,1,1,12'h000,8'h00,0,8'h00, 6'b100000,8'h00,16'h0000,4'h0,8'h00);
    vecs[1]  = mk(0,1,1,12'h123,8'h25,0,8'h00, 6'b100000,8'h00,16'h5123,4'h2,8'h00);
    vecs[2]  = mk(1,0,1,12'h000,8'h00,0,8'h00, 6'b010000,8'h00,16'h5123,4'h2,8'h00);
    vecs[3]  = mk(1,0,1,12'h000,8'h00,0,8'h00, 6'b010000,8'h00,16'h5123,4'h2,8'h00);
    vecs[4]  = mk(1,0,1,12'h000,8'h00,0,8'h00, 6'b010000,8'h00,16'h5123,4'h2,8'h00);
    vecs[5]  = mk(1,0,1,12'h000,8'h00,1,8'hA5, 6'b100100,8'hA5,16'h5123,4'h2,8'h00);
    vecs[6]  = mk(1,0,1,12'h000,8'h00,0,8'h00, 6'b100100,8'hA5,16'h5123,4'h2,8'h00);
    vecs[7]  = mk(1,1,1,12'h000,8'h00,0,8'h00, 6'b100000,8'hA5,16'h5123,4'h2,8'h00);
    vecs[8]  = mk(0,1,1,12'hFFF,8'h0F,0,8'h00, 6'b100000,8'hA5,16'hFFFF,4'h0,8'h00);
    vecs[9]  = mk(1,1,0,12'h000,8'h3C,0,8'h00, 6'b001000,8'hA5,16'hFFFF,4'h0,8'h3C);
    vecs[10] = mk(1,1,0,12'h000,8'h3C,0,8'h00, 6'b001000,8'hA5,16'hFFFF,4'h0,8'h3C);
    vecs[11] = mk(1,1,0,12'h000,8'h3C,1,8'h00, 6'b100000,8'hA5,16'hFFFF,4'h0,8'h3C);
    vecs[12] = mk(1,1,1,12'h000,8'h00,0,8'h00, 6'b100000,8'hA5,16'hFFFF,4'h0,8'h3C);
    vecs[13] = mk(0,1,1,12'h000,8'hA0,0,8'h00, 6'b100001,8'hA5,16'h0000,4'hA,8'h3C);
    vecs[14] = mk(1,1,1,12'h000,8'h00,0,8'h00, 6'b100000,8'hA5,16'h0000,4'hA,8'h3C);
    vecs[15] = mk(1,0,0,12'h000,8'h00,0,8'h00, 6'b100010,8'hA5,16'h0000,4'hA,8'h3C);
    vecs[16] = mk(1,0,1,12'h000,8'h00,0,8'h00, 6'b100000,8'hA5,16'h0000,4'hA,8'h3C);
    vecs[17] = mk(0,1,1,12'h456,8'h31,0,8'h00, 6'b100000,8'hA5,16'h1456,4'h3,8'h3C);
    vecs[18] = mk(1,0,1,12'h000,8'h00,0,8'h00, 6'b010000,8'hA5,16'h1456,4'h3,8'h3C);
    vecs[19] = mk(0,0,1,12'h789,8'hFF,0,8'h00, 6'b010010,8'hA5,16'h1456,4'h3,8'h3C);
    vecs[20] = mk(1,0,1,12'h000,8'h00,1,8'h5A, 6'b100100,8'h5A,16'h1456,4'h3,8'h3C);
    vecs[21] = mk(1,1,1,12'h000,8'h00,0,8'h00, 6'b100000,8'h5A,16'h1456,4'h3,8'h3C);
    vecs[22] = mk(0,1,1,12'h001,8'h02,0,8'h00, 6'b100000,8'h5A,16'h2001,4'h0,8'h3C);
    vecs[23] = mk(0,0,1,12'h002,8'h13,0,8'h00, 6'b100000,8'h5A,16'h3002,4'h1,8'h3C);
    vecs[24] = mk(1,0,1,12'h000,8'h00,0,8'h00, 6'b010000,8'h5A,16'h3002,4'h1,8'h3C);
    vecs[25] = mk(1,0,1,12'h000,8'h00,1,8'h77, 6'b100100,8'h77,16'h3002,4'h1,8'h3C);
    vecs[26] = mk(1,1,1,12'h000,8'h00,0,8'h00, 6'b100000,8'h77,16'h3002,4'h1,8'h3C);
    vecs[27] = mk(1,1,1,12'h000,8'h00,1,8'h11, 6'b100000,8'h77,16'h3002,4'h1,8'h3C);

    step();
    chk("reset_values", outs(), {6'b100000, 8'h00, 16'h0000, 4'h0, 8'h00});
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 28; i++) begin
      drive(vecs[i].ads_n, vecs[i].rd_n, vecs[i].wr_n, vecs[i].a, vecs[i].d,
            vecs[i].ack, vecs[i].rdata);
      step();
      chk($sformatf("vec%0d", i), outs(),
          {vecs[i].ctl, vecs[i].dout, vecs[i].maddr, vecs[i].cyc, vecs[i].wd});
    end

    drive(0, 1, 1, 12'h0AB, 8'h04, 0, 8'h00);
    step();
    chk("wait_latch", 42'(mem_addr), 42'(16'h40AB));
    drive(1, 1, 1, 12'h000, 8'h00, 0, 8'h00);
`ifdef SCMP_RESP_TIMEOUT_EN
    for (int unsigned i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("timeout_err_c%0d", i), 42'(err), 42'(i == 4));
    end
    drive(0, 1, 1, 12'h0CD, 8'h01, 0, 8'h00);
    step();
    chk("timeout_next_ads", 42'(mem_addr), 42'(16'h10CD));
    drive(1, 0, 1, 12'h000, 8'h00, 0, 8'h00);
    step();
    chk("timeout_next_rd", 42'({mem_rd, hold_n}), 42'(2'b10));
`else
    for (int unsigned i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("wait_idle_c%0d", i), 42'({err, mem_rd, mem_wr, hold_n}), 42'(4'b0001));
    end
    drive(1, 0, 1, 12'h000, 8'h00, 0, 8'h00);
    step();
    chk("wait_late_rd", 42'({mem_rd, hold_n}), 42'(2'b10));
`endif
    drive(1, 0, 1, 12'h000, 8'h00, 1, 8'hC3);
    step();
    chk("wait_rd_data", 42'({D_oe, hold_n, D_o}), 42'({2'b11, 8'hC3}));
    drive(1, 1, 1, 12'h000, 8'h00, 0, 8'h00);
    step();
    chk("wait_rd_end", 42'({D_oe, D_o}), 42'({1'b0, 8'hC3}));

    drive(0, 1, 1, 12'h321, 8'h07, 0, 8'h00);
    step();
    drive(1, 1, 0, 12'h000, 8'h99, 0, 8'h00);
    step();
    chk("rst_pre_wr", 42'({mem_wr, hold_n, mem_wdata}), 42'({2'b10, 8'h99}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", outs(), {6'b100000, 8'h00, 16'h0000, 4'h0, 8'h00});
    step();
    rst_n = 1'b1;
    drive(1, 0, 1, 12'h000, 8'h00, 0, 8'h00);
    step();
    chk("rst_idle_ignores_rd", 42'({mem_rd, mem_wr, hold_n, err}), 42'(4'b0010));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
